// File: rtl/vga_pkg.sv
// Shared types and screen constants for the VGA plot arbiter.
// Holds owner_t, pixel_t and the visible screen size.
package vga_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LOCK0 = 2'b01,
    LOCK1 = 2'b10
  } owner_t;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } pixel_t;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  function automatic logic off_screen(
    input pixel_t p,
    input int     w,
    input int     h
  );
    return (int'(p.x) >= w) || (int'(p.y) >= h);
  endfunction

endpackage

// File: rtl/vga_plot_arbiter_if.sv
// Per-pixel request/grant bundle from one drawing engine.
// master: engine side (req, pixel, lock out; gnt in). slave: arbiter side.
interface vga_plot_arbiter_if;

  logic       req;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       lock;
  logic       gnt;

  modport master (
    output req,
    output x,
    output y,
    output colour,
    output lock,
    input  gnt
  );

  modport slave (
    input  req,
    input  x,
    input  y,
    input  colour,
    input  lock,
    output gnt
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant with an internal priority pointer.
// Ports: clk, rst_n, en (gate), req[1:0] in; gnt[1:0] combinational out.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic prio;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      unique case (1'b1)
        req[0] && (!req[1] || !prio): gnt = 2'b01;
        req[1] && (!req[0] ||  prio): gnt = 2'b10;
        default:                      gnt = 2'b00;
      endcase
    end
  end

  // After a grant the other side becomes favoured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= 1'b0;
    end else if (|gnt) begin
      prio <= gnt[0];
    end
  end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Shares the VGA plot port between two engines with burst locking and clipping.
// Ports: clk, rst_n, rq0/rq1 (slave), registered vga_* outputs, owner, clip_count.
module vga_plot_arbiter
  import vga_pkg::*;
#(
  parameter int SCREEN_W = vga_pkg::SCREEN_W,
  parameter int SCREEN_H = vga_pkg::SCREEN_H,
  parameter int CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  vga_plot_arbiter_if.slave    rq0,
  vga_plot_arbiter_if.slave    rq1,
  output logic [7:0]           vga_x,
  output logic [6:0]           vga_y,
  output logic [2:0]           vga_colour,
  output logic                 vga_plot,
  output logic [1:0]           owner,
  output logic [CNT_W-1:0]     clip_count
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_LOCK0 = LOCK0;
  localparam logic [1:0] S_LOCK1 = LOCK1;

  logic [1:0] state;
  logic [1:0] state_nx;
  logic [1:0] req_m;
  logic [1:0] gnt;
  pixel_t     pix;
  logic       clip;

  assign owner = state;

  // A locked owner hides the other requester from the arbiter.
  assign req_m[0] = rq0.req && (state != S_LOCK1);
  assign req_m[1] = rq1.req && (state != S_LOCK0);

  rr_arbiter2 u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (rst_n),
    .req   (req_m),
    .gnt   (gnt)
  );

  assign rq0.gnt = gnt[0];
  assign rq1.gnt = gnt[1];

  always_comb begin
    pix = '0;
    if (gnt[1]) begin
      pix.x      = rq1.x;
      pix.y      = rq1.y;
      pix.colour = rq1.colour;
    end else begin
      pix.x      = rq0.x;
      pix.y      = rq0.y;
      pix.colour = rq0.colour;
    end
  end

  assign clip = off_screen(pix, SCREEN_W, SCREEN_H);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (gnt[0] && rq0.lock) begin
          state_nx = S_LOCK0;
        end else if (gnt[1] && rq1.lock) begin
          state_nx = S_LOCK1;
        end
      end
      S_LOCK0: if (!rq0.lock) state_nx = S_IDLE;
      S_LOCK1: if (!rq1.lock) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Clipped pixels are acknowledged but leave the output untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_plot   <= 1'b0;
      clip_count <= '0;
    end else begin
      vga_plot <= 1'b0;
      if (|gnt) begin
        if (clip) begin
          if (clip_count != '1) begin
            clip_count <= clip_count + CNT_W'(1);
          end
        end else begin
          vga_x      <= pix.x;
          vga_y      <= pix.y;
          vga_colour <= pix.colour;
          vga_plot   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed self-checking bench for vga_plot_arbiter.
// Hand-computed expectations for grant, output and ownership.
module tb_vga_plot_arbiter;

  logic        clk;
  logic        rst_n;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic [1:0]  owner;
  logic [15:0] clip_count;

  int total;
  int bad;

  vga_plot_arbiter_if p0 ();
  vga_plot_arbiter_if p1 ();

  vga_plot_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rq0        (p0),
    .rq1        (p1),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot),
    .owner      (owner),
    .clip_count (clip_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set0(
    input logic       r,
    input logic [7:0] x,
    input logic [6:0] y,
    input logic [2:0] c,
    input logic       l
  );
    p0.req = r; p0.x = x; p0.y = y;
    p0.colour = c; p0.lock = l;
  endtask

  task automatic set1(
    input logic       r,
    input logic [7:0] x,
    input logic [6:0] y,
    input logic [2:0] c,
    input logic       l
  );
    p1.req = r; p1.x = x; p1.y = y;
    p1.colour = c; p1.lock = l;
  endtask

  // Check grants mid-cycle, then step to just after the edge.
  task automatic cyc(
    input string tag,
    input logic  e0,
    input logic  e1
  );
    @(negedge clk);
    chk({tag, ".gnt0"}, 32'(p0.gnt), 32'(e0));
    chk({tag, ".gnt1"}, 32'(p1.gnt), 32'(e1));
    @(posedge clk);
    #1;
  endtask

  task automatic out(
    input string      tag,
    input logic [7:0] x,
    input logic [6:0] y,
    input logic [2:0] c,
    input logic       p
  );
    chk({tag, ".x"}, 32'(vga_x), 32'(x));
    chk({tag, ".y"}, 32'(vga_y), 32'(y));
    chk({tag, ".c"}, 32'(vga_colour), 32'(c));
    chk({tag, ".plot"}, 32'(vga_plot), 32'(p));
  endtask

  logic [7:0] bx [8];
  logic [6:0] by [8];

  initial begin
    total = 0;
    bad   = 0;
    bx = '{8'd81, 8'd79, 8'd81, 8'd79, 8'd82, 8'd78, 8'd80, 8'd80};
    by = '{7'd59, 7'd61, 7'd61, 7'd59, 7'd60, 7'd60, 7'd62, 7'd58};
    rst_n = 1'b0;
    set0(1'b1, 8'd3, 7'd3, 3'd1, 1'b0);
    set1(1'b1, 8'd4, 7'd4, 3'd2, 1'b0);
    #2;
    out("rst", 8'd0, 7'd0, 3'd0, 1'b0);
    chk("rst.owner", 32'(owner), 32'd0);
    chk("rst.clip", 32'(clip_count), 32'd0);
    chk("rst.gnt0", 32'(p0.gnt), 32'd0);
    chk("rst.gnt1", 32'(p1.gnt), 32'd0);
    set0(1'b0, 8'd0, 7'd0, 3'd0, 1'b0);
    set1(1'b0, 8'd0, 7'd0, 3'd0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // single requester 1
    set1(1'b1, 8'd79, 7'd61, 3'b010, 1'b0);
    cyc("single", 1'b0, 1'b1);
    out("single", 8'd79, 7'd61, 3'd2, 1'b1);
    chk("single.owner", 32'(owner), 32'd0);
    set1(1'b0, 8'd0, 7'd0, 3'd0, 1'b0);

    // contention: prio is back on requester 0
    set0(1'b1, 8'd10, 7'd20, 3'd1, 1'b0);
    set1(1'b1, 8'd30, 7'd40, 3'd5, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) begin
        cyc("cont", 1'b1, 1'b0);
        out("cont", 8'd10, 7'd20, 3'd1, 1'b1);
      end else begin
        cyc("cont", 1'b0, 1'b1);
        out("cont", 8'd30, 7'd40, 3'd5, 1'b1);
      end
    end
    set0(1'b0, 8'd0, 7'd0, 3'd0, 1'b0);
    set1(1'b0, 8'd0, 7'd0, 3'd0, 1'b0);
    cyc("idle", 1'b0, 1'b0);
    out("idle", 8'd30, 7'd40, 3'd5, 1'b0);

    // one req0 pixel so requester 1 wins the next contention
    set0(1'b1, 8'd5, 7'd5, 3'd7, 1'b0);
    cyc("pre", 1'b1, 1'b0);
    out("pre", 8'd5, 7'd5, 3'd7, 1'b1);

    // burst lock by requester 1 with req0 held high
    set0(1'b1, 8'd10, 7'd20, 3'd1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      set1(1'b1, bx[i], by[i], 3'd4, (i != 7));
      cyc("burst", 1'b0, 1'b1);
      out("burst", bx[i], by[i], 3'd4, 1'b1);
      chk("burst.owner", 32'(owner),
          (i != 7) ? 32'd2 : 32'd0);
    end
    set1(1'b0, 8'd0, 7'd0, 3'd0, 1'b0);
    cyc("rel", 1'b1, 1'b0);
    out("rel", 8'd10, 7'd20, 3'd1, 1'b1);

    // clipping and boundaries
    set0(1'b1, 8'd160, 7'd10, 3'd3, 1'b0);
    cyc("clipx", 1'b1, 1'b0);
    out("clipx", 8'd10, 7'd20, 3'd1, 1'b0);
    chk("clipx.cnt", 32'(clip_count), 32'd1);
    set0(1'b1, 8'd159, 7'd119, 3'd6, 1'b0);
    cyc("edge", 1'b1, 1'b0);
    out("edge", 8'd159, 7'd119, 3'd6, 1'b1);
    set0(1'b1, 8'd0, 7'd120, 3'd2, 1'b0);
    cyc("clipy", 1'b1, 1'b0);
    out("clipy", 8'd159, 7'd119, 3'd6, 1'b0);
    chk("clipy.cnt", 32'(clip_count), 32'd2);

    // reset in the middle of a requester 0 burst
    set0(1'b1, 8'd1, 7'd2, 3'd3, 1'b1);
    cyc("lk0", 1'b1, 1'b0);
    out("lk0", 8'd1, 7'd2, 3'd3, 1'b1);
    chk("lk0.owner", 32'(owner), 32'd1);
    rst_n = 1'b0;
    #1;
    out("mrst", 8'd0, 7'd0, 3'd0, 1'b0);
    chk("mrst.owner", 32'(owner), 32'd0);
    chk("mrst.cnt", 32'(clip_count), 32'd0);
    chk("mrst.gnt0", 32'(p0.gnt), 32'd0);
    #1;
    rst_n = 1'b1;
    set0(1'b0, 8'd0, 7'd0, 3'd0, 1'b0);
    set1(1'b1, 8'd7, 7'd8, 3'd1, 1'b0);
    cyc("post", 1'b0, 1'b1);
    out("post", 8'd7, 7'd8, 3'd1, 1'b1);
    chk("post.owner", 32'(owner), 32'd0);
    set1(1'b0, 8'd0, 7'd0, 3'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
